// File: rtl/scan_pkg.sv
// Shared types and sizing helpers for the mux channel scanner.
package scan_pkg;

  localparam int NUM_CH_DEF = 8;
  localparam int SEL_W_DEF  = 3;
  localparam int DWELL_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    OUTPUT
  } scan_state_t;

  // Dwell counter holds values 0..dwell-1, so it never needs more than clog2(dwell) bits.
  function automatic int cnt_width(input int dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(DWELL_DEF);

endpackage

// File: rtl/chan_next_find.sv
// Combinational search over a channel mask: next enabled channel above the
// current one, whether any exists, and the lowest enabled channel.
module chan_next_find
  import scan_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  next_above,
  output logic              none_above,
  output logic [SEL_W-1:0]  lowest
);

  // Scanning downward lets the last hit win, giving the smallest qualifying index.
  always_comb begin
    next_above = '0;
    none_above = 1'b1;
    lowest     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        next_above = SEL_W'(i);
        none_above = 1'b0;
      end
      if (mask[i]) begin
        lowest = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux_channel_scanner.sv
// Drives mux select across a snapshot of enabled channels, waits a dwell
// time on each, captures the sample and streams it out with its channel tag.
module mux_channel_scanner
  import scan_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int SEL_W  = SEL_W_DEF,
  parameter int DWELL  = DWELL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] en_mask,
  output logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] mux_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [SEL_W-1:0]  m_chan,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = cnt_width(DWELL);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

  scan_state_t       state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [NUM_CH-1:0] snap, snap_d;
  logic [SEL_W-1:0]  sel_d;
  logic [DATA_W-1:0] data_d;
  logic [SEL_W-1:0]  chan_d;
  logic              last_d;
  logic              done_d;

  logic [NUM_CH-1:0] find_mask;
  logic [SEL_W-1:0]  next_above;
  logic              none_above;
  logic [SEL_W-1:0]  lowest;

  // In IDLE the snapshot is not yet taken, so search the live mask directly.
  assign find_mask = (state == IDLE) ? en_mask : snap;

  chan_next_find #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_find (
    .mask       (find_mask),
    .cur        (sel),
    .next_above (next_above),
    .none_above (none_above),
    .lowest     (lowest)
  );

  assign m_valid = (state == OUTPUT);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      snap   <= '0;
      sel    <= '0;
      m_data <= '0;
      m_chan <= '0;
      m_last <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      snap   <= snap_d;
      sel    <= sel_d;
      m_data <= data_d;
      m_chan <= chan_d;
      m_last <= last_d;
      done   <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    snap_d  = snap;
    sel_d   = sel;
    data_d  = m_data;
    chan_d  = m_chan;
    last_d  = m_last;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (en_mask != '0) begin
            snap_d  = en_mask;
            sel_d   = lowest;
            cnt_d   = CNT_LOAD;
            state_d = SETTLE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          data_d  = mux_out;
          chan_d  = sel;
          last_d  = none_above;
          state_d = OUTPUT;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      OUTPUT: begin
        if (m_ready) begin
          if (!none_above) begin
            sel_d   = next_above;
            cnt_d   = CNT_LOAD;
            state_d = SETTLE;
          end else if (continuous) begin
            sel_d   = lowest;
            cnt_d   = CNT_LOAD;
            state_d = SETTLE;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Randomized self-checking bench for mux_channel_scanner against a
// transaction-level model of the expected beat sequence.
module tb_mux_channel_scanner;

  localparam int DATA_W = 8;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;
  localparam int DWELL  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              continuous;
  logic [NUM_CH-1:0] en_mask;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] mux_out;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [SEL_W-1:0]  m_chan;
  logic              m_last;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] mux_in [NUM_CH];

  int vectors     = 0;
  int miscompares = 0;

  mux_channel_scanner #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W),
    .DWELL  (DWELL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .continuous (continuous),
    .en_mask    (en_mask),
    .sel        (sel),
    .mux_out    (mux_out),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_chan     (m_chan),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done)
  );

  assign mux_out = mux_in[sel];

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete scan: start, follow every expected beat, stall, finish.
  task automatic applyStimulus(input logic [7:0] mask, input int passes, input int stallMax,
                               input bit fixedStall, input bit disturb, input bit ramp);
    int expChan[$];
    int highest;
    int perPass;
    int lastPassStart;
    int cycles;
    int n;
    logic [DATA_W-1:0] holdData;
    logic [SEL_W-1:0]  holdSel;
    logic [SEL_W-1:0]  holdChan;

    for (int ch = 0; ch < NUM_CH; ch++)
      mux_in[ch] = ramp ? DATA_W'(1 << ch) : DATA_W'($urandom);
    highest = -1;
    perPass = 0;
    for (int ch = 0; ch < NUM_CH; ch++)
      if (mask[ch]) begin
        highest = ch;
        perPass++;
      end
    for (int p = 0; p < passes; p++)
      for (int ch = 0; ch < NUM_CH; ch++)
        if (mask[ch]) expChan.push_back(ch);
    lastPassStart = (passes - 1) * perPass;

    en_mask    = mask;
    continuous = (passes > 1);
    start      = 1'b1;
    step();
    start = 1'b0;

    if (mask == 8'h00) begin
      checkOutput("empty_done", done, 1);
      checkOutput("empty_busy", busy, 0);
      checkOutput("empty_valid", m_valid, 0);
      step();
      checkOutput("empty_done_off", done, 0);
      checkOutput("empty_valid2", m_valid, 0);
      checkOutput("empty_busy2", busy, 0);
      return;
    end
    checkOutput("busy_start", busy, 1);

    for (int idx = 0; idx < expChan.size(); idx++) begin
      cycles = 0;
      holdSel = sel;
      while (!m_valid && cycles < 40) begin
        step();
        cycles++;
        if (!m_valid) checkOutput("settle_sel", sel, holdSel);
      end
      if (!m_valid) begin
        checkOutput("valid_timeout", 0, 1);
        return;
      end
      checkOutput("latency", cycles, DWELL);
      checkOutput("sel", sel, expChan[idx]);
      checkOutput("chan", m_chan, expChan[idx]);
      checkOutput("data", m_data, mux_in[expChan[idx]]);
      checkOutput("last", m_last, (expChan[idx] == highest));
      checkOutput("busy", busy, 1);
      if (idx == lastPassStart) continuous = 1'b0;

      holdData = m_data;
      holdSel  = sel;
      holdChan = m_chan;
      n = fixedStall ? stallMax : $urandom_range(0, stallMax);
      m_ready = 1'b0;
      repeat (n) begin
        if (disturb) begin
          en_mask = NUM_CH'($urandom);
          start   = 1'($urandom_range(0, 1));
        end
        step();
        checkOutput("stall_valid", m_valid, 1);
        checkOutput("stall_data", m_data, holdData);
        checkOutput("stall_sel", sel, holdSel);
        checkOutput("stall_chan", m_chan, holdChan);
      end
      start   = 1'b0;
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      checkOutput("valid_drop", m_valid, 0);
      if (idx == expChan.size() - 1) begin
        checkOutput("done_pulse", done, 1);
        checkOutput("busy_end", busy, 0);
        step();
        checkOutput("done_off", done, 0);
        checkOutput("idle_valid", m_valid, 0);
      end else begin
        checkOutput("done_early", done, 0);
        checkOutput("busy_mid", busy, 1);
      end
    end
  endtask

  initial begin
    int cycles;
    rst        = 1'b1;
    start      = 1'b0;
    continuous = 1'b0;
    en_mask    = '0;
    m_ready    = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) mux_in[ch] = '0;
    repeat (2) step();
    checkOutput("rst_sel", sel, 0);
    checkOutput("rst_valid", m_valid, 0);
    checkOutput("rst_data", m_data, 0);
    checkOutput("rst_chan", m_chan, 0);
    checkOutput("rst_last", m_last, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    rst = 1'b0;
    step();

    applyStimulus(8'hFF, 1, 0, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'hA4, 1, 5, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h81, 2, 0, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1, 0, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h5A, 1, 4, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h10, 3, 2, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h80, 1, 1, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 8; t++)
      applyStimulus(8'($urandom_range(1, 255)), $urandom_range(1, 2), 3, 1'b0, 1'($urandom_range(0, 1)), 1'b0);

    // Reset while a beat is presented must drop it silently.
    en_mask    = 8'hFF;
    continuous = 1'b1;
    start      = 1'b1;
    step();
    start  = 1'b0;
    cycles = 0;
    while (!m_valid && cycles < 40) begin
      step();
      cycles++;
    end
    checkOutput("pre_rst_valid", m_valid, 1);
    rst = 1'b1;
    step();
    checkOutput("mid_rst_sel", sel, 0);
    checkOutput("mid_rst_valid", m_valid, 0);
    checkOutput("mid_rst_data", m_data, 0);
    checkOutput("mid_rst_chan", m_chan, 0);
    checkOutput("mid_rst_last", m_last, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_done", done, 0);
    rst        = 1'b0;
    continuous = 1'b0;
    m_ready    = 1'b1;
    repeat (6) begin
      step();
      checkOutput("post_rst_done", done, 0);
      checkOutput("post_rst_valid", m_valid, 0);
    end
    m_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
